axis_rx_status_if: RTL and testbench

Receive-side counterpart of the TX control-stream generator. It consumes the six-word AXI Ethernet RX status stream (`rxs`) and validates each frame. From every well-formed frame it extracts the received byte count and delivers it as a 12-bit length stream to the packet-processing logic. Malformed frames and length overflows are flagged and, optionally, counted.

---
 rtl/axis_rxs_pkg.sv | 18 +
 rtl/rxs_len_fifo.sv | 63 ++++++
 rtl/axis_rx_status_if.sv | 150 +++++++++++++++
 tb/tb_axis_rx_status_if.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rxs_pkg.sv
// Shared definitions for the AXI Ethernet RX status stream parser.
// Holds the parser state encoding and the fixed status frame layout.
package axis_rxs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        LEN     = 2'd2,
        DISCARD = 2'd3
    } rxs_state_t;

    localparam logic [3:0] RXS_FLAG     = 4'h5;
    localparam int         RXS_WORDS    = 6;
    localparam int         RXS_LEN_WORD = 5;
    localparam int         RXS_LEN_LSB  = 0;
    localparam int         RXS_LEN_MSB  = 15;

endpackage

// File: rtl/rxs_len_fifo.sv
// Synchronous length buffer with registered storage, level reporting, and
// acceptance of a push while full when a pop happens in the same cycle.
module rxs_len_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_L);
    assign level = count;
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Head entry is zeroed while empty so the reset value of the output is defined.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_rx_status_if.sv
// RX status stream parser: validates six-word status frames and emits the
// saturated byte count as a length stream. Macro RXS_ERR_CNT_EN adds error counters.
module axis_rx_status_if
    import axis_rxs_pkg::*;
#(
    parameter int C_S_AXIS_RXS_TDATA_WIDTH = 32,
    parameter int LEN_WIDTH                = 12,
    parameter int LEN_FIFO_DEPTH           = 16
) (
    input  logic                                s_axis_rxs_aclk,
    input  logic                                s_axis_rxs_areset,
    input  logic [C_S_AXIS_RXS_TDATA_WIDTH-1:0] s_axis_rxs_tdata,
    input  logic [3:0]                          s_axis_rxs_tkeep,
    input  logic                                s_axis_rxs_tvalid,
    input  logic                                s_axis_rxs_tlast,
    output logic                                s_axis_rxs_tready,
    output logic [LEN_WIDTH-1:0]                m_axis_len_tdata,
    output logic                                m_axis_len_tvalid,
    input  logic                                m_axis_len_tready,
    output logic                                rx_frame_err,
    output logic                                rx_len_drop,
    output logic [$clog2(LEN_FIFO_DEPTH):0]     len_fifo_level,
    output logic [15:0]                         err_frame_cnt,
    output logic [15:0]                         len_drop_cnt
);

    localparam logic [15:0] LEN_MAX = 16'((32'd1 << LEN_WIDTH) - 1);

    rxs_state_t           state, next_state;
    logic [2:0]           word_cnt, next_cnt;
    logic                 beat;
    logic                 flag_ok;
    logic                 frame_err;
    logic                 len_push;
    logic                 len_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 len_drop;
    logic [15:0]          byte_cnt;
    logic [LEN_WIDTH-1:0] len_val;
    logic                 unused_bits;

    assign unused_bits = ^{s_axis_rxs_tkeep, s_axis_rxs_tdata[27:16]};

    assign s_axis_rxs_tready = !s_axis_rxs_areset;
    assign beat     = s_axis_rxs_tvalid && s_axis_rxs_tready;
    assign flag_ok  = (s_axis_rxs_tdata[31:28] == RXS_FLAG);
    assign byte_cnt = s_axis_rxs_tdata[RXS_LEN_MSB:RXS_LEN_LSB];
    assign len_val  = (byte_cnt > LEN_MAX) ? '1 : byte_cnt[LEN_WIDTH-1:0];

    assign m_axis_len_tvalid = !fifo_empty;
    assign len_pop  = m_axis_len_tvalid && m_axis_len_tready;
    assign len_drop = len_push && fifo_full && !len_pop;

    always_ff @(posedge s_axis_rxs_aclk) begin
        if (s_axis_rxs_areset) begin
            state        <= IDLE;
            word_cnt     <= '0;
            rx_frame_err <= 1'b0;
            rx_len_drop  <= 1'b0;
        end else begin
            state        <= next_state;
            word_cnt     <= next_cnt;
            rx_frame_err <= frame_err;
            rx_len_drop  <= len_drop;
        end
    end

    // Word counter tracks words 1..4; word4 moves the parser onto the length word.
    always_comb begin
        next_state = state;
        next_cnt   = word_cnt;
        frame_err  = 1'b0;
        len_push   = 1'b0;
        if (beat) begin
            case (state)
                IDLE: begin
                    if (flag_ok && !s_axis_rxs_tlast) begin
                        next_cnt   = 3'd1;
                        next_state = HDR;
                    end else begin
                        frame_err  = 1'b1;
                        next_state = s_axis_rxs_tlast ? IDLE : DISCARD;
                    end
                end
                HDR: begin
                    if (s_axis_rxs_tlast) begin
                        frame_err  = 1'b1;
                        next_state = IDLE;
                    end else if (word_cnt == 3'(RXS_LEN_WORD - 1)) begin
                        next_state = LEN;
                    end else begin
                        next_cnt = word_cnt + 3'd1;
                    end
                end
                LEN: begin
                    if (s_axis_rxs_tlast) begin
                        len_push   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        next_state = DISCARD;
                    end
                end
                DISCARD: begin
                    if (s_axis_rxs_tlast) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    rxs_len_fifo #(
        .WIDTH (LEN_WIDTH),
        .DEPTH (LEN_FIFO_DEPTH)
    ) u_len_fifo (
        .aclk      (s_axis_rxs_aclk),
        .areset    (s_axis_rxs_areset),
        .push      (len_push),
        .push_data (len_val),
        .pop       (len_pop),
        .dout      (m_axis_len_tdata),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (len_fifo_level)
    );

`ifdef RXS_ERR_CNT_EN
    // Counters update alongside their pulse registers and stick at all ones.
    always_ff @(posedge s_axis_rxs_aclk) begin
        if (s_axis_rxs_areset) begin
            err_frame_cnt <= '0;
            len_drop_cnt  <= '0;
        end else begin
            if (frame_err && (err_frame_cnt != 16'hFFFF)) begin
                err_frame_cnt <= err_frame_cnt + 16'd1;
            end
            if (len_drop && (len_drop_cnt != 16'hFFFF)) begin
                len_drop_cnt <= len_drop_cnt + 16'd1;
            end
        end
    end
`else
    assign err_frame_cnt = '0;
    assign len_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_axis_rx_status_if.sv
// Directed bench for axis_rx_status_if: frame parsing, saturation, error
// handling, length buffer overflow, back-to-back frames and mid-frame reset.
module tb_axis_rx_status_if;

`ifdef RXS_ERR_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic        clk;
    logic        areset;
    logic [31:0] rxs_tdata;
    logic [3:0]  rxs_tkeep;
    logic        rxs_tvalid;
    logic        rxs_tlast;
    logic        rxs_tready;
    logic [11:0] len_tdata;
    logic        len_tvalid;
    logic        len_tready;
    logic        frame_err;
    logic        len_drop;
    logic [4:0]  level;
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int drop_pulses = 0;

    axis_rx_status_if dut (
        .s_axis_rxs_aclk   (clk),
        .s_axis_rxs_areset (areset),
        .s_axis_rxs_tdata  (rxs_tdata),
        .s_axis_rxs_tkeep  (rxs_tkeep),
        .s_axis_rxs_tvalid (rxs_tvalid),
        .s_axis_rxs_tlast  (rxs_tlast),
        .s_axis_rxs_tready (rxs_tready),
        .m_axis_len_tdata  (len_tdata),
        .m_axis_len_tvalid (len_tvalid),
        .m_axis_len_tready (len_tready),
        .rx_frame_err      (frame_err),
        .rx_len_drop       (len_drop),
        .len_fifo_level    (level),
        .err_frame_cnt     (err_cnt),
        .len_drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
        if (len_drop === 1'b1) drop_pulses++;
    end

    // Presents one beat and returns just after the edge that accepts it.
    task automatic beat(input logic [31:0] d, input logic l);
        @(negedge clk);
        rxs_tvalid = 1'b1;
        rxs_tdata  = d;
        rxs_tlast  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxs_tvalid = 1'b0;
        rxs_tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] len);
        beat(32'h5000_0000, 1'b0);
        for (int i = 1; i < 5; i++) beat(32'hA5A5_0000 + 32'(i), 1'b0);
        beat({16'h0000, len}, 1'b1);
    endtask

    task automatic test_reset;
        areset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rxs_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tready: got %b expected 0", rxs_tready); end
        checks++; if (len_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_len_tvalid: got %b expected 0", len_tvalid); end
        checks++; if (len_tdata !== 12'h000) begin errors++; $display("[TB] FAIL reset_len_tdata: got %h expected 000", len_tdata); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (len_drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_len_drop: got %b expected 0", len_drop); end
        checks++; if (level !== 5'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        areset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (rxs_tready !== 1'b1) begin errors++; $display("[TB] FAIL run_tready: got %b expected 1", rxs_tready); end
    endtask

    task automatic test_good_frame;
        int base;
        base = err_pulses;
        len_tready = 1'b0;
        beat(32'h5000_0000, 1'b0);
        for (int i = 1; i < 5; i++) beat(32'h0000_1000 * i, 1'b0);
        checks++; if (len_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL good_no_fallthrough: got %b expected 0", len_tvalid); end
        beat(32'h0000_05EA, 1'b1);
        checks++; if (len_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL good_latency_tvalid: got %b expected 1", len_tvalid); end
        checks++; if (len_tdata !== 12'h5EA) begin errors++; $display("[TB] FAIL good_len: got %h expected 5ea", len_tdata); end
        checks++; if (level !== 5'd1) begin errors++; $display("[TB] FAIL good_level: got %0d expected 1", level); end
        idle(2);
        checks++; if (len_tdata !== 12'h5EA) begin errors++; $display("[TB] FAIL good_hold: got %h expected 5ea", len_tdata); end
        len_tready = 1'b1;
        @(posedge clk);
        #1;
        len_tready = 1'b0;
        checks++; if (len_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL good_pop_tvalid: got %b expected 0", len_tvalid); end
        checks++; if (level !== 5'd0) begin errors++; $display("[TB] FAIL good_pop_level: got %0d expected 0", level); end
        checks++; if (err_pulses !== base) begin errors++; $display("[TB] FAIL good_no_err: got %0d expected %0d", err_pulses, base); end
    endtask

    task automatic test_saturate;
        len_tready = 1'b0;
        send_frame(16'h2345);
        checks++; if (len_tdata !== 12'hFFF) begin errors++; $display("[TB] FAIL sat_len: got %h expected fff", len_tdata); end
        len_tready = 1'b1;
        idle(1);
        len_tready = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("[TB] FAIL sat_level: got %0d expected 0", level); end
    endtask

    task automatic test_early_tlast;
        int base;
        base = err_pulses;
        len_tready = 1'b0;
        beat(32'h5000_0000, 1'b0);
        beat(32'h0000_0001, 1'b0);
        beat(32'h0000_0002, 1'b0);
        beat(32'h0000_0003, 1'b1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL early_err_pulse: got %b expected 1", frame_err); end
        idle(1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL early_err_single: got %b expected 0", frame_err); end
        checks++; if (level !== 5'd0) begin errors++; $display("[TB] FAIL early_no_push: got %0d expected 0", level); end
        checks++; if (err_pulses !== base + 1) begin errors++; $display("[TB] FAIL early_err_count: got %0d expected %0d", err_pulses, base + 1); end
        send_frame(16'h0040);
        checks++; if (len_tdata !== 12'h040) begin errors++; $display("[TB] FAIL early_next_len: got %h expected 040", len_tdata); end
        len_tready = 1'b1;
        idle(1);
        len_tready = 1'b0;
    endtask

    task automatic test_bad_flag;
        int base;
        base = err_pulses;
        len_tready = 1'b0;
        beat(32'h4000_0000, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL badflag_pulse: got %b expected 1", frame_err); end
        beat(32'h5000_0000, 1'b0);
        beat(32'h0000_0002, 1'b0);
        beat(32'h0000_0003, 1'b0);
        beat(32'h0000_0004, 1'b0);
        beat(32'h0000_05EA, 1'b1);
        idle(2);
        checks++; if (err_pulses !== base + 1) begin errors++; $display("[TB] FAIL badflag_err_count: got %0d expected %0d", err_pulses, base + 1); end
        checks++; if (level !== 5'd0) begin errors++; $display("[TB] FAIL badflag_discard: got %0d expected 0", level); end
        checks++; if (err_cnt !== 16'(2 * CNT_ON)) begin errors++; $display("[TB] FAIL badflag_err_cnt: got %0d expected %0d", err_cnt, 2 * CNT_ON); end
    endtask

    task automatic test_fifo_full;
        int base;
        logic [11:0] exp_len;
        base = drop_pulses;
        len_tready = 1'b0;
        for (int f = 1; f <= 17; f++) send_frame(16'(f));
        checks++; if (len_drop !== 1'b1) begin errors++; $display("[TB] FAIL full_drop_pulse: got %b expected 1", len_drop); end
        checks++; if (level !== 5'd16) begin errors++; $display("[TB] FAIL full_level: got %0d expected 16", level); end
        beat(32'h5000_0000, 1'b0);
        for (int i = 1; i < 5; i++) beat(32'h0000_0000 + 32'(i), 1'b0);
        len_tready = 1'b1;
        beat(32'h0000_0012, 1'b1);
        len_tready = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("[TB] FAIL full_pushpop_level: got %0d expected 16", level); end
        checks++; if (len_drop !== 1'b0) begin errors++; $display("[TB] FAIL full_pushpop_nodrop: got %b expected 0", len_drop); end
        idle(1);
        checks++; if (drop_pulses !== base + 1) begin errors++; $display("[TB] FAIL full_drop_count: got %0d expected %0d", drop_pulses, base + 1); end
        checks++; if (drop_cnt !== 16'(CNT_ON)) begin errors++; $display("[TB] FAIL full_drop_cnt: got %0d expected %0d", drop_cnt, CNT_ON); end
        len_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_len = (i < 15) ? 12'(i + 2) : 12'h012;
            checks++; if (len_tvalid !== 1'b1 || len_tdata !== exp_len) begin errors++; $display("[TB] FAIL full_drain_%0d: got v=%b d=%h expected v=1 d=%h", i, len_tvalid, len_tdata, exp_len); end
            @(posedge clk);
            #1;
        end
        len_tready = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("[TB] FAIL full_drained_level: got %0d expected 0", level); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] exp_q [3];
        exp_q[0] = 12'hFFF;
        exp_q[1] = 12'hFFF;
        exp_q[2] = 12'h000;
        len_tready = 1'b0;
        send_frame(16'h0FFF);
        send_frame(16'h1000);
        send_frame(16'h0000);
        idle(1);
        checks++; if (level !== 5'd3) begin errors++; $display("[TB] FAIL b2b_level: got %0d expected 3", level); end
        len_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (len_tvalid !== 1'b1 || len_tdata !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_len_%0d: got v=%b d=%h expected v=1 d=%h", i, len_tvalid, len_tdata, exp_q[i]); end
            @(posedge clk);
            #1;
        end
        len_tready = 1'b0;
        checks++; if (len_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %b expected 0", len_tvalid); end
    endtask

    task automatic test_reset_midframe;
        int base;
        len_tready = 1'b0;
        send_frame(16'h0077);
        idle(1);
        checks++; if (level !== 5'd1) begin errors++; $display("[TB] FAIL midrst_prefill: got %0d expected 1", level); end
        beat(32'h5000_0000, 1'b0);
        beat(32'h0000_0001, 1'b0);
        @(negedge clk);
        rxs_tdata = 32'h0000_0002;
        areset    = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rxs_tready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tready: got %b expected 0", rxs_tready); end
        checks++; if (level !== 5'd0 || len_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flush: got lvl=%0d v=%b expected lvl=0 v=0", level, len_tvalid); end
        areset = 1'b0;
        idle(1);
        base = err_pulses;
        beat(32'h5000_0000, 1'b0);
        for (int i = 1; i < 5; i++) beat(32'h0000_0000 + 32'(i), 1'b0);
        checks++; if (len_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_empty_before: got %b expected 0", len_tvalid); end
        beat(32'h0000_0123, 1'b1);
        checks++; if (len_tdata !== 12'h123 || level !== 5'd1) begin errors++; $display("[TB] FAIL midrst_len: got d=%h lvl=%0d expected d=123 lvl=1", len_tdata, level); end
        idle(1);
        checks++; if (err_pulses !== base) begin errors++; $display("[TB] FAIL midrst_no_err: got %0d expected %0d", err_pulses, base); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL midrst_err_cnt: got %0d expected 0", err_cnt); end
        len_tready = 1'b1;
        @(posedge clk);
        #1;
        len_tready = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("[TB] FAIL midrst_final_level: got %0d expected 0", level); end
    endtask

    initial begin
        areset     = 1'b1;
        rxs_tdata  = '0;
        rxs_tkeep  = 4'hF;
        rxs_tvalid = 1'b0;
        rxs_tlast  = 1'b0;
        len_tready = 1'b0;
        test_reset();
        test_good_frame();
        test_saturate();
        test_early_tlast();
        test_bad_flag();
        test_fifo_full();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
